// File: rtl/clock_pkg.sv
// Shared digit widths, BCD limits and colour width for the time-of-day core.
package clock_pkg;

  localparam int UNITS_W            = 4;
  localparam int SEC_U_W            = 4;
  localparam int SEC_D_W            = 3;
  localparam int MIN_U_W            = 4;
  localparam int MIN_D_W            = 3;
  localparam int HRS_U_W            = 4;
  localparam int HRS_D_W            = 2;

  localparam int UNITS_MAX          = 9;
  localparam int TENS_MAX           = 5;
  localparam int HRS_MAX_D          = 2;
  localparam int HRS_MAX_U_AT_MAX_D = 3;

  localparam int COLOR_W            = 4;

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD counter with a configurable wrap point (59 for sec/min, 23 for hours).
// Out-of-range digits are folded back to 0 on the next increment.
module bcd_field_counter #(
  parameter int TENS_W                = 3,
  parameter int TENS_MAX              = 5,
  parameter int UNITS_MAX_AT_TENS_MAX = 9
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               inc,
  output logic [clock_pkg::UNITS_W-1:0]      units,
  output logic [TENS_W-1:0]                  tens,
  output logic                               wrap
);

  localparam int                  UW    = clock_pkg::UNITS_W;
  localparam logic [UW-1:0]       U_MAX = UW'(clock_pkg::UNITS_MAX);
  localparam logic [UW-1:0]       U_TOP = UW'(UNITS_MAX_AT_TENS_MAX);
  localparam logic [TENS_W-1:0]   T_MAX = TENS_W'(TENS_MAX);

  logic [UW-1:0]     r_units;
  logic [TENS_W-1:0] r_tens;
  logic [UW-1:0]     w_units_nxt;
  logic [TENS_W-1:0] w_tens_nxt;
  logic              w_at_max;

  // Wrap detection also catches illegal tens values so they clear on the next increment.
  always_comb begin
    w_at_max = (r_tens > T_MAX) || ((r_tens == T_MAX) && (r_units >= U_TOP));
    wrap     = inc & w_at_max;
  end

  // Next-digit decode.
  always_comb begin
    w_units_nxt = r_units;
    w_tens_nxt  = r_tens;
    if (inc) begin
      if (w_at_max) begin
        w_units_nxt = {UW{1'b0}};
        w_tens_nxt  = {TENS_W{1'b0}};
      end else if (r_units >= U_MAX) begin
        w_units_nxt = {UW{1'b0}};
        w_tens_nxt  = r_tens + TENS_W'(1);
      end else begin
        w_units_nxt = r_units + UW'(1);
      end
    end else begin
      w_units_nxt = r_units;
      w_tens_nxt  = r_tens;
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_units <= {UW{1'b0}};
      r_tens  <= {TENS_W{1'b0}};
    end else begin
      r_units <= w_units_nxt;
      r_tens  <= w_tens_nxt;
    end
  end

  assign units = r_units;
  assign tens  = r_tens;

endmodule

// File: rtl/bcd_timekeeper.sv
// Time-of-day core: 1 Hz prescaler, BCD hh:mm:ss fields with set pulses, and the
// per-minute colour offset for the display stage.
module bcd_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = 31_500_000,
  parameter int PRESC_W = 26
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               adj_sec,
  input  logic               adj_min,
  input  logic               adj_hrs,
  output logic [SEC_U_W-1:0] sec_u,
  output logic [SEC_D_W-1:0] sec_d,
  output logic [MIN_U_W-1:0] min_u,
  output logic [MIN_D_W-1:0] min_d,
  output logic [HRS_U_W-1:0] hrs_u,
  output logic [HRS_D_W-1:0] hrs_d,
  output logic [COLOR_W-1:0] color_offset,
  output logic               sec_tick
);

  logic [PRESC_W-1:0] r_presc;
  logic               r_sec_tick;
  logic [COLOR_W-1:0] r_color;

  logic w_tick;
  logic w_sec_inc;
  logic w_min_inc;
  logic w_hrs_inc;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_unused_hrs_wrap;

  // Carries are gated by the tick so a set pulse never ripples into the next field.
  always_comb begin
    w_tick    = (r_presc == PRESC_W'(CLK_HZ - 1));
    w_sec_inc = w_tick | adj_sec;
    w_min_inc = (w_tick & w_sec_wrap) | adj_min;
    w_hrs_inc = (w_tick & w_sec_wrap & w_min_wrap) | adj_hrs;
  end

  // Prescaler, tick pulse and colour offset; adj_sec restarts the second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc    <= {PRESC_W{1'b0}};
      r_sec_tick <= 1'b0;
      r_color    <= {COLOR_W{1'b0}};
    end else begin
      r_sec_tick <= w_tick;
      if (adj_sec || w_tick) begin
        r_presc <= {PRESC_W{1'b0}};
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
      if (w_min_inc) begin
        r_color <= r_color + COLOR_W'(1);
      end else begin
        r_color <= r_color;
      end
    end
  end

  bcd_field_counter #(
    .TENS_W               (SEC_D_W),
    .TENS_MAX             (TENS_MAX),
    .UNITS_MAX_AT_TENS_MAX(UNITS_MAX)
  ) u_sec (
    .clk  (clk),
    .rst_n(reset_n),
    .inc  (w_sec_inc),
    .units(sec_u),
    .tens (sec_d),
    .wrap (w_sec_wrap)
  );

  bcd_field_counter #(
    .TENS_W               (MIN_D_W),
    .TENS_MAX             (TENS_MAX),
    .UNITS_MAX_AT_TENS_MAX(UNITS_MAX)
  ) u_min (
    .clk  (clk),
    .rst_n(reset_n),
    .inc  (w_min_inc),
    .units(min_u),
    .tens (min_d),
    .wrap (w_min_wrap)
  );

  bcd_field_counter #(
    .TENS_W               (HRS_D_W),
    .TENS_MAX             (HRS_MAX_D),
    .UNITS_MAX_AT_TENS_MAX(HRS_MAX_U_AT_MAX_D)
  ) u_hrs (
    .clk  (clk),
    .rst_n(reset_n),
    .inc  (w_hrs_inc),
    .units(hrs_u),
    .tens (hrs_d),
    .wrap (w_unused_hrs_wrap)
  );

  assign color_offset = r_color;
  assign sec_tick     = r_sec_tick;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed bench for bcd_timekeeper with a 4-cycle second; times compared as 0xHHMMSS.
module tb_bcd_timekeeper;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       adj_sec = 1'b0;
  logic       adj_min = 1'b0;
  logic       adj_hrs = 1'b0;
  logic [3:0] sec_u;
  logic [2:0] sec_d;
  logic [3:0] min_u;
  logic [2:0] min_d;
  logic [3:0] hrs_u;
  logic [1:0] hrs_d;
  logic [3:0] color_offset;
  logic       sec_tick;

  int n_pass = 0;
  int n_total = 0;

  bcd_timekeeper #(.CLK_HZ(4), .PRESC_W(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .adj_sec     (adj_sec),
    .adj_min     (adj_min),
    .adj_hrs     (adj_hrs),
    .sec_u       (sec_u),
    .sec_d       (sec_d),
    .min_u       (min_u),
    .min_d       (min_d),
    .hrs_u       (hrs_u),
    .hrs_d       (hrs_d),
    .color_offset(color_offset),
    .sec_tick    (sec_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] t_now();
    return {8'h00, 2'b00, hrs_d, hrs_u, 1'b0, min_d, min_u, 1'b0, sec_d, sec_u};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // Holding adj_sec keeps the prescaler from ticking while fields are loaded.
  task automatic set_fields(input int h, input int m, input int s);
    int n;
    n = (h > m) ? h : m;
    n = (s > n) ? s : n;
    for (int i = 0; i < n; i++) begin
      adj_hrs = (i < h);
      adj_min = (i < m);
      adj_sec = (i < s);
      @(posedge clk);
      #1;
    end
    adj_hrs = 1'b0;
    adj_min = 1'b0;
    adj_sec = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    bit seen;
    seen = 1'b0;
    n = 99;
    for (int i = 1; i <= 8; i++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (sec_tick) begin
          seen = 1'b1;
          n = i;
        end
      end
    end
  endtask

  initial begin
    int n;
    int pulses;
    int off_grid;

    // 1: asynchronous reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_time", t_now(), 32'h000000);
    chk("rst_color", {28'd0, color_offset}, 32'd0);
    chk("rst_tick", {31'd0, sec_tick}, 32'd0);
    #2;
    reset_n = 1'b1;
    idle(12);
    chk("run_3s", t_now(), 32'h000003);
    chk("tick_at_3s", {31'd0, sec_tick}, 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_time", t_now(), 32'h000000);
    chk("async_tick", {31'd0, sec_tick}, 32'd0);
    #1;
    reset_n = 1'b1;
    wait_tick(n);
    chk("first_tick_lat", n, 32'd4);

    // 2: prescaler period
    do_reset();
    pulses = 0;
    off_grid = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (sec_tick) begin
        pulses++;
        if ((i % 4) != 0) off_grid++;
      end
    end
    chk("tick_count", pulses, 32'd10);
    chk("tick_grid", off_grid, 32'd0);
    chk("run_10s", t_now(), 32'h000010);
    chk("run_color", {28'd0, color_offset}, 32'd0);

    // 3: midnight rollover
    do_reset();
    set_fields(23, 59, 58);
    chk("set_235958", t_now(), 32'h235958);
    chk("set_color", {28'd0, color_offset}, 32'd11);
    wait_tick(n);
    chk("to_235959", t_now(), 32'h235959);
    wait_tick(n);
    chk("midnight", t_now(), 32'h000000);
    chk("midnight_color", {28'd0, color_offset}, 32'd12);

    // 4: set pulses never carry
    do_reset();
    set_fields(0, 59, 59);
    chk("set_005959", t_now(), 32'h005959);
    adj_sec = 1'b1;
    idle(1);
    adj_sec = 1'b0;
    chk("adjsec_nocarry", t_now(), 32'h005900);
    chk("adjsec_color", {28'd0, color_offset}, 32'd11);
    adj_min = 1'b1;
    idle(1);
    adj_min = 1'b0;
    chk("adjmin_nocarry", t_now(), 32'h000000);
    chk("adjmin_color", {28'd0, color_offset}, 32'd12);

    // 5: tick coincident with adj_sec
    do_reset();
    set_fields(0, 0, 5);
    idle(3);
    adj_sec = 1'b1;
    idle(1);
    adj_sec = 1'b0;
    chk("tick_adjsec", t_now(), 32'h000006);
    chk("tick_adjsec_pulse", {31'd0, sec_tick}, 32'd1);
    wait_tick(n);
    chk("restart_lat", n, 32'd4);
    chk("after_restart", t_now(), 32'h000007);

    // 6: carry coincident with adj_min, and 09->10 hours
    do_reset();
    set_fields(0, 12, 59);
    chk("set_001259", t_now(), 32'h001259);
    idle(3);
    adj_min = 1'b1;
    idle(1);
    adj_min = 1'b0;
    chk("carry_adjmin", t_now(), 32'h001300);
    chk("carry_adjmin_color", {28'd0, color_offset}, 32'd13);
    do_reset();
    set_fields(9, 59, 59);
    chk("set_095959", t_now(), 32'h095959);
    wait_tick(n);
    chk("hrs_09_to_10", t_now(), 32'h100000);
    chk("hrs_color", {28'd0, color_offset}, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
